// File: rtl/secp256k1_jb_to_affine.sv
// secp256k1_jb_to_affine
//   Converts a Jacobian point (X,Y,Z) into affine coordinates
//   x = X/Z^2 and y = Y/Z^3 mod p, where p = 2^256 - 2^32 - 977.
//   Z is inverted as Z^(p-2) by left-to-right square-and-multiply.
//   The block owns no multiplier. Every product goes through the external
//   multiplier port, and only one request is outstanding at a time.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_p, i_val, o_rdy      input point {x,y,z}, 256 bits each, with handshake
//   o_x, o_y, o_err        affine result; o_err flags Z == 0 (or Z == p)
//   o_val, i_rdy           output handshake
//   o_mult_a/b/ctl/val     multiply request towards secp256k1_mult_mod
//   i_mult_rdy             request accepted
//   i_mult_dat/val         returned product a*b mod p
//   o_mult_rdy             product ready (high in WAIT, IDLE and DONE)
module secp256k1_jb_to_affine #(
  parameter logic [15:0] CTL_TAG = 16'h0000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [767:0] i_p,
  input  logic         i_val,
  output logic         o_rdy,
  output logic [255:0] o_x,
  output logic [255:0] o_y,
  output logic         o_err,
  output logic         o_val,
  input  logic         i_rdy,
  output logic [255:0] o_mult_a,
  output logic [255:0] o_mult_b,
  output logic [15:0]  o_mult_ctl,
  output logic         o_mult_val,
  input  logic         i_mult_rdy,
  input  logic [255:0] i_mult_dat,
  input  logic         i_mult_val,
  output logic         o_mult_rdy
);

  localparam logic [255:0] P_MOD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  // Fermat exponent p-2; bit 255 is consumed by the initial acc = Z
  localparam logic [255:0] EXP_E = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

  typedef enum logic [2:0] {IDLE, EXP_SQ, EXP_MUL, ZI2, ZI3, MX, MY, DONE} state_t;
  typedef enum logic [1:0] {PH_LOAD, PH_ISSUE, PH_WAIT} phase_t;

  state_t       state_r;
  phase_t       phase_r;
  logic [255:0] x_r, y_r, z_r, acc_r, t2_r, t3_r;
  logic [7:0]   idx_r;
  logic [255:0] in_x_s, in_y_s, in_z_s;
  logic         z_zero_s;
  logic [255:0] op_a_s, op_b_s;

  assign in_x_s     = i_p[767:512];
  assign in_y_s     = i_p[511:256];
  assign in_z_s     = i_p[255:0];
  // Z equal to p is the same residue as 0 and has no inverse either
  assign z_zero_s   = (in_z_s == 256'd0) || (in_z_s == P_MOD);
  assign o_mult_ctl = CTL_TAG;

  // Operand pair of the multiply that belongs to the current state
  always_comb begin
    op_a_s = acc_r;
    op_b_s = acc_r;
    case (state_r)
      EXP_SQ:  begin op_a_s = acc_r; op_b_s = acc_r; end
      EXP_MUL: begin op_a_s = acc_r; op_b_s = z_r;   end
      ZI2:     begin op_a_s = acc_r; op_b_s = acc_r; end
      ZI3:     begin op_a_s = t2_r;  op_b_s = acc_r; end
      MX:      begin op_a_s = x_r;   op_b_s = t2_r;  end
      MY:      begin op_a_s = y_r;   op_b_s = t3_r;  end
      default: begin op_a_s = acc_r; op_b_s = acc_r; end
    endcase
  end

  // Control FSM, datapath registers and all registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= IDLE;
      phase_r    <= PH_LOAD;
      x_r        <= 256'd0;
      y_r        <= 256'd0;
      z_r        <= 256'd0;
      acc_r      <= 256'd0;
      t2_r       <= 256'd0;
      t3_r       <= 256'd0;
      idx_r      <= 8'd0;
      o_rdy      <= 1'b0;
      o_val      <= 1'b0;
      o_err      <= 1'b0;
      o_x        <= 256'd0;
      o_y        <= 256'd0;
      o_mult_a   <= 256'd0;
      o_mult_b   <= 256'd0;
      o_mult_val <= 1'b0;
      o_mult_rdy <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // keep draining stray products (e.g. after a reset) so a shared
          // multiplier never stalls on us
          o_mult_rdy <= 1'b1;
          if (i_val && o_rdy) begin
            o_rdy <= 1'b0;
            x_r   <= in_x_s;
            y_r   <= in_y_s;
            z_r   <= in_z_s;
            if (z_zero_s) begin
              state_r <= DONE;
              o_val   <= 1'b1;
              o_err   <= 1'b1;
              o_x     <= 256'd0;
              o_y     <= 256'd0;
            end else begin
              acc_r      <= in_z_s;
              idx_r      <= 8'd254;
              phase_r    <= PH_LOAD;
              state_r    <= EXP_SQ;
              o_mult_rdy <= 1'b0;
            end
          end else begin
            o_rdy <= 1'b1;
          end
        end
        EXP_SQ, EXP_MUL, ZI2, ZI3, MX, MY: begin
          case (phase_r)
            PH_LOAD: begin
              o_mult_a   <= op_a_s;
              o_mult_b   <= op_b_s;
              o_mult_val <= 1'b1;
              phase_r    <= PH_ISSUE;
            end
            PH_ISSUE: begin
              if (i_mult_rdy) begin
                o_mult_val <= 1'b0;
                o_mult_rdy <= 1'b1;
                phase_r    <= PH_WAIT;
              end
            end
            PH_WAIT: begin
              if (i_mult_val) begin
                o_mult_rdy <= 1'b0;
                phase_r    <= PH_LOAD;
                case (state_r)
                  EXP_SQ: begin
                    acc_r <= i_mult_dat;
                    if (EXP_E[idx_r]) begin
                      state_r <= EXP_MUL;
                    end else if (idx_r == 8'd0) begin
                      state_r <= ZI2;
                    end else begin
                      idx_r <= idx_r - 8'd1;
                    end
                  end
                  EXP_MUL: begin
                    acc_r <= i_mult_dat;
                    if (idx_r == 8'd0) begin
                      state_r <= ZI2;
                    end else begin
                      idx_r   <= idx_r - 8'd1;
                      state_r <= EXP_SQ;
                    end
                  end
                  ZI2: begin
                    t2_r    <= i_mult_dat;
                    state_r <= ZI3;
                  end
                  ZI3: begin
                    t3_r    <= i_mult_dat;
                    state_r <= MX;
                  end
                  MX: begin
                    o_x     <= i_mult_dat;
                    state_r <= MY;
                  end
                  MY: begin
                    o_y        <= i_mult_dat;
                    o_val      <= 1'b1;
                    o_err      <= 1'b0;
                    o_mult_rdy <= 1'b1;
                    state_r    <= DONE;
                  end
                  default: state_r <= IDLE;
                endcase
              end
            end
            default: phase_r <= PH_LOAD;
          endcase
        end
        DONE: begin
          o_mult_rdy <= 1'b1;
          if (o_val && i_rdy) begin
            state_r <= IDLE;
            o_val   <= 1'b0;
            o_err   <= 1'b0;
            o_rdy   <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secp256k1_jb_to_affine.sv
`timescale 1ns/1ps
module tb_secp256k1_jb_to_affine;

  localparam logic [255:0] P_MOD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] GX  = 256'h79be667ef9dcbbac55a06295ce870b07029bfcdb2dce28d959f2815b16f81798;
  localparam logic [255:0] GY  = 256'h483ada7726a3c4655da4fbfc0e1108a8fd17b448a68554199c47d08ffb10d4b8;
  localparam logic [255:0] G2X = 256'hc6047f9441ed7d6d3045406e95c07cd85c778e4b8cef3ca7abac09b95c709ee5;
  localparam logic [255:0] G2Y = 256'h1ae168fea63dc339a3c58419466ceaeef7f632653266d0e1236431a950cfe52a;
  localparam logic [255:0] G3X = 256'hf9308a019258c31049344f85f89d5229b531c845836f99b08601f113bce036f9;
  localparam logic [255:0] G3Y = 256'h388f7b0f632de8140fe337e62a37f3566500a99934c2231b6cb9fd7584b8e672;
  localparam logic [255:0] Z2G = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
  localparam logic [255:0] Z3G = 256'hdeadbeefcafef00d_0badc0de12345678_55aa55aa33cc33cc_0f0f0f0f98765431;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [767:0] i_p = 768'd0;
  logic         i_val = 1'b0;
  logic         o_rdy;
  logic [255:0] o_x, o_y;
  logic         o_err, o_val;
  logic         i_rdy = 1'b0;
  logic [255:0] o_mult_a, o_mult_b;
  logic [15:0]  o_mult_ctl;
  logic         o_mult_val;
  logic         i_mult_rdy = 1'b1;
  logic [255:0] i_mult_dat = 256'd0;
  logic         i_mult_val = 1'b0;
  logic         o_mult_rdy;

  int errors = 0;
  int checks = 0;
  int stall_viol = 0;
  int rdy_viol = 0;

  // multiplier model state
  bit           mult_bp = 1'b0;
  int           mult_lat = 1;
  int           mult_reqs = 0;
  int           overlap_errs = 0;
  bit           busy = 1'b0;
  bit           req_hs = 1'b0;
  bit           resp_hs = 1'b0;
  int           lat_cnt = 0;
  logic [255:0] pa, pb;

  always #5 clk = ~clk;

  secp256k1_jb_to_affine dut (
    .i_clk(clk), .i_rst(i_rst), .i_p(i_p), .i_val(i_val), .o_rdy(o_rdy),
    .o_x(o_x), .o_y(o_y), .o_err(o_err), .o_val(o_val), .i_rdy(i_rdy),
    .o_mult_a(o_mult_a), .o_mult_b(o_mult_b), .o_mult_ctl(o_mult_ctl),
    .o_mult_val(o_mult_val), .i_mult_rdy(i_mult_rdy), .i_mult_dat(i_mult_dat),
    .i_mult_val(i_mult_val), .o_mult_rdy(o_mult_rdy)
  );

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t, m;
    t = {256'd0, a} * {256'd0, b};
    m = t % {256'd0, P_MOD};
    return m[255:0];
  endfunction

  // Multiplier model: handshakes decided at one negedge take effect at the
  // following posedge and are processed at the negedge after that.
  always @(negedge clk) begin
    if (resp_hs) begin
      i_mult_val = 1'b0;
      busy = 1'b0;
    end
    if (req_hs) begin
      if (busy) overlap_errs++;
      busy = 1'b1;
      lat_cnt = mult_lat;
      mult_reqs++;
    end
    if (busy && !i_mult_val) begin
      if (lat_cnt <= 0) begin
        i_mult_val = 1'b1;
        i_mult_dat = mulmod(pa, pb);
      end else begin
        lat_cnt--;
      end
    end
    i_mult_rdy = mult_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    req_hs = o_mult_val && i_mult_rdy;
    if (req_hs) begin
      pa = o_mult_a;
      pb = o_mult_b;
    end
    resp_hs = i_mult_val && o_mult_rdy;
  end

  task automatic run_job(input logic [255:0] jx, input logic [255:0] jy, input logic [255:0] jz,
                         input bit bp, output logic [255:0] rx, output logic [255:0] ry,
                         output logic rerr, output int first_val, output int nreq);
    int t, r0;
    bit done, held;
    logic [512:0] hold;
    rx = 'x; ry = 'x; rerr = 1'bx; first_val = -1; done = 1'b0; held = 1'b0; hold = '0;
    t = 0;
    while (!o_rdy && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (o_rdy !== 1'b1) begin errors++; $display("FAIL job_ready: o_rdy=%b required 1", o_rdy); end
    r0 = mult_reqs;
    i_p = {jx, jy, jz};
    i_val = 1'b1;
    @(negedge clk);
    // while busy, keep offering a junk job that must be ignored
    i_val = bp;
    i_p = ~{jx, jy, jz};
    t = 0;
    while (!done && t < 40000) begin
      if (o_rdy) rdy_viol++;
      if (o_val) begin
        if (first_val < 0) first_val = t;
        if (held && ({o_x, o_y, o_err} !== hold)) stall_viol++;
        i_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (i_rdy) begin
          rx = o_x; ry = o_y; rerr = o_err; done = 1'b1; i_val = 1'b0;
        end else begin
          held = 1'b1; hold = {o_x, o_y, o_err};
        end
      end else begin
        i_rdy = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    i_rdy = 1'b0;
    i_val = 1'b0;
    nreq = mult_reqs - r0;
    checks++;
    if (!done) begin errors++; $display("FAIL job_timeout: o_val=%b after %0d cycles, required 1", o_val, t); end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_val = 1'b0; i_rdy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_rdy, o_val, o_err, o_mult_val, o_mult_rdy} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctl: rdy,val,err,mval,mrdy=%b required 00000", {o_rdy, o_val, o_err, o_mult_val, o_mult_rdy});
    end
    checks++;
    if ({o_x, o_y} !== 512'd0) begin errors++; $display("FAIL reset_xy: x=%h y=%h required 0", o_x, o_y); end
    i_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_rdy, o_mult_rdy} !== 2'b11) begin errors++; $display("FAIL reset_rdy: rdy,mrdy=%b required 11", {o_rdy, o_mult_rdy}); end
  endtask

  task automatic test_generator();
    logic [255:0] rx, ry; logic rerr; int fv, nr;
    mult_lat = 1;
    run_job(GX, GY, 256'd1, 1'b0, rx, ry, rerr, fv, nr);
    checks++; if (rx !== GX) begin errors++; $display("FAIL gen_x: got %h required %h", rx, GX); end
    checks++; if (ry !== GY) begin errors++; $display("FAIL gen_y: got %h required %h", ry, GY); end
    checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL gen_err: got %b required 0", rerr); end
    checks++; if (nr != 507) begin errors++; $display("FAIL gen_mult_count: got %0d required 507", nr); end
  endtask

  task automatic test_2g();
    logic [255:0] rx, ry, zz, jx, jy; logic rerr; int fv, nr;
    zz = mulmod(Z2G, Z2G);
    jx = mulmod(G2X, zz);
    jy = mulmod(G2Y, mulmod(zz, Z2G));
    mult_lat = 0;
    run_job(jx, jy, Z2G, 1'b0, rx, ry, rerr, fv, nr);
    checks++; if (rx !== G2X) begin errors++; $display("FAIL 2g_x: got %h required %h", rx, G2X); end
    checks++; if (ry !== G2Y) begin errors++; $display("FAIL 2g_y: got %h required %h", ry, G2Y); end
    checks++; if (nr != 507) begin errors++; $display("FAIL 2g_mult_count: got %0d required 507", nr); end
  endtask

  task automatic test_back_pressure();
    logic [255:0] rx, ry, zz, jx, jy; logic rerr; int fv, nr;
    zz = mulmod(Z3G, Z3G);
    jx = mulmod(G3X, zz);
    jy = mulmod(G3Y, mulmod(zz, Z3G));
    mult_bp = 1'b1; mult_lat = 3; stall_viol = 0; rdy_viol = 0;
    run_job(jx, jy, Z3G, 1'b1, rx, ry, rerr, fv, nr);
    mult_bp = 1'b0;
    checks++; if (rx !== G3X) begin errors++; $display("FAIL 3g_x: got %h required %h", rx, G3X); end
    checks++; if (ry !== G3Y) begin errors++; $display("FAIL 3g_y: got %h required %h", ry, G3Y); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL 3g_stall_stable: %0d changes while stalled, required 0", stall_viol); end
    checks++; if (rdy_viol != 0) begin errors++; $display("FAIL 3g_busy_rdy: o_rdy high %0d times while busy, required 0", rdy_viol); end
    checks++; if (nr != 507) begin errors++; $display("FAIL 3g_mult_count: got %0d required 507", nr); end
  endtask

  task automatic test_zero_z();
    logic [255:0] rx, ry; logic rerr; int fv, nr;
    mult_lat = 1;
    run_job(GX, GY, 256'd0, 1'b0, rx, ry, rerr, fv, nr);
    checks++; if (fv < 0 || fv > 3) begin errors++; $display("FAIL z0_latency: o_val after %0d cycles, required 0..3", fv); end
    checks++; if (rerr !== 1'b1) begin errors++; $display("FAIL z0_err: got %b required 1", rerr); end
    checks++; if ({rx, ry} !== 512'd0) begin errors++; $display("FAIL z0_xy: x=%h y=%h required 0", rx, ry); end
    checks++; if (nr != 0) begin errors++; $display("FAIL z0_mult_count: got %0d required 0", nr); end
    run_job(GX, GY, 256'd1, 1'b0, rx, ry, rerr, fv, nr);
    checks++; if ({rx, ry, rerr} !== {GX, GY, 1'b0}) begin errors++; $display("FAIL z0_next_job: x=%h y=%h err=%b required G, err 0", rx, ry, rerr); end
    run_job(GX, GY, P_MOD, 1'b0, rx, ry, rerr, fv, nr);
    checks++; if ({rerr, rx, ry} !== {1'b1, 512'd0}) begin errors++; $display("FAIL zp_err: err=%b x=%h y=%h required err 1, x=y=0", rerr, rx, ry); end
    checks++; if (nr != 0) begin errors++; $display("FAIL zp_mult_count: got %0d required 0", nr); end
  endtask

  task automatic test_x_equal_p();
    logic [255:0] rx, ry; logic rerr; int fv, nr;
    run_job(P_MOD, GY, 256'd1, 1'b0, rx, ry, rerr, fv, nr);
    checks++; if (rx !== 256'd0) begin errors++; $display("FAIL xp_x: got %h required 0", rx); end
    checks++; if (ry !== GY) begin errors++; $display("FAIL xp_y: got %h required %h", ry, GY); end
  endtask

  task automatic test_reset_mid_job();
    logic [255:0] rx, ry, zz, jx, jy; logic rerr; int fv, nr, t, r0;
    zz = mulmod(Z2G, Z2G);
    jx = mulmod(G2X, zz);
    jy = mulmod(G2Y, mulmod(zz, Z2G));
    mult_lat = 2;
    t = 0;
    while (!o_rdy && t < 200) begin @(negedge clk); t++; end
    r0 = mult_reqs;
    i_p = {jx, jy, Z2G}; i_val = 1'b1;
    @(negedge clk);
    i_val = 1'b0;
    t = 0;
    while ((mult_reqs - r0) < 100 && t < 5000) begin @(negedge clk); t++; end
    checks++;
    if ((mult_reqs - r0) < 100) begin errors++; $display("FAIL rst_mid_progress: %0d requests, required 100", mult_reqs - r0); end
    i_rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_rdy, o_val, o_err, o_mult_val, o_mult_rdy, o_x, o_y} !== 517'd0) begin
      errors++; $display("FAIL rst_mid_zero: rdy,val,err,mval,mrdy=%b x=%h y=%h required all 0", {o_rdy, o_val, o_err, o_mult_val, o_mult_rdy}, o_x, o_y);
    end
    i_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy: o_rdy=%b required 1", o_rdy); end
    t = 0;
    while ((busy || i_mult_val) && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (busy || i_mult_val) begin errors++; $display("FAIL rst_mid_drain: stray product pending=%b required 0", busy); end
    run_job(jx, jy, Z2G, 1'b0, rx, ry, rerr, fv, nr);
    checks++; if ({rx, ry} !== {G2X, G2Y}) begin errors++; $display("FAIL rst_mid_2g: x=%h y=%h required %h %h", rx, ry, G2X, G2Y); end
  endtask

  task automatic test_single_outstanding();
    checks++;
    if (overlap_errs != 0) begin errors++; $display("FAIL one_outstanding: %0d overlapping requests, required 0", overlap_errs); end
  endtask

  initial begin
    test_reset();
    test_generator();
    test_2g();
    test_back_pressure();
    test_zero_z();
    test_x_equal_p();
    test_reset_mid_job();
    test_single_outstanding();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
